vga_scan_ctrl: RTL and testbench

- Generates VGA raster timing and frame-buffer read requests in the 25 MHz pixel clock domain.
- Sits between the board-level pixel clock divider and the VGA pins: it consumes the divided 25 MHz clock and drives hs/vs/r/g/b.
- Fetches one pixel per active cycle from a synchronous-read frame buffer.
- Delays sync and blanking through a pipeline so they stay aligned with the returned pixel data.

---
 rtl/vga_scan_ctrl.sv | 159 +++++++++++++++
 tb/tb_vga_scan_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/vga_scan_ctrl.sv
// VGA raster timing generator with frame-buffer read requests, one pixel clock domain.
// Latency: counter position at cycle n appears on hs/vs/r/g/b at cycle n+2+RD_LATENCY.
// No back-pressure: the frame buffer must return pix_data exactly RD_LATENCY cycles after pix_rd.
module vga_scan_ctrl #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int RD_LATENCY = 1,
  parameter int ADDR_W     = 19
) (
  input  logic              clk,
  input  logic              rst,
  output logic              pix_rd,
  output logic [ADDR_W-1:0] pix_addr,
  input  logic [23:0]       pix_data,
  output logic              hs,
  output logic              vs,
  output logic [7:0]        r,
  output logic [7:0]        g,
  output logic [7:0]        b,
  output logic              frame_start
);

  // Raster geometry
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HC_W    = $clog2(H_TOTAL);
  localparam int VC_W    = $clog2(V_TOTAL);

  // Delay from stage 0 to the output register input: one request stage plus memory latency
  localparam int DLY = 1 + RD_LATENCY;

  // Counter comparison points, sized to the counters
  localparam logic [HC_W-1:0] H_LAST     = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0] V_LAST     = VC_W'(V_TOTAL - 1);
  localparam logic [HC_W-1:0] H_ACT_END  = HC_W'(H_ACTIVE);
  localparam logic [VC_W-1:0] V_ACT_END  = VC_W'(V_ACTIVE);
  localparam logic [HC_W-1:0] HS_START   = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0] HS_END     = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VC_W-1:0] VS_START   = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0] VS_END     = VC_W'(V_ACTIVE + V_FP + V_SYNC);

  // Stage 0 state
  logic [HC_W-1:0]   h_cnt;
  logic [VC_W-1:0]   v_cnt;
  logic [ADDR_W-1:0] addr_cnt;

  // Stage 0 decode
  logic h_wrap;
  logic v_wrap;
  logic active;
  logic hs_raw;
  logic vs_raw;
  logic first_pix;

  // Delay line, bit 0 is the newest entry
  logic [DLY-1:0] dly_active;
  logic [DLY-1:0] dly_hs;
  logic [DLY-1:0] dly_vs;
  logic [DLY-1:0] dly_first;

  // Decode the current raster position into window and sync flags
  always_comb begin
    h_wrap    = (h_cnt == H_LAST);
    v_wrap    = (v_cnt == V_LAST);
    active    = (h_cnt < H_ACT_END) && (v_cnt < V_ACT_END);
    hs_raw    = (h_cnt >= HS_START) && (h_cnt < HS_END);
    // vertical sync follows v_cnt only, so it flips on line boundaries
    vs_raw    = (v_cnt >= VS_START) && (v_cnt < VS_END);
    first_pix = (h_cnt == '0) && (v_cnt == '0);
  end

  // Horizontal and vertical raster counters
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + VC_W'(1);
      end else begin
        h_cnt <= h_cnt + HC_W'(1);
      end
    end
  end

  // Linear pixel address: steps once per visible pixel, restarts at end of frame
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_cnt <= '0;
    end else if (h_wrap && v_wrap) begin
      addr_cnt <= '0;
    end else if (active) begin
      addr_cnt <= addr_cnt + ADDR_W'(1);
    end
  end

  // Stage 1: issue the frame-buffer read; address holds while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_rd   <= 1'b0;
      pix_addr <= '0;
    end else begin
      pix_rd <= active;
      if (active) begin
        pix_addr <= addr_cnt;
      end
    end
  end

  // Carry window/sync/first-pixel flags alongside the outstanding read
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_active <= '0;
      dly_hs     <= '0;
      dly_vs     <= '0;
      dly_first  <= '0;
    end else begin
      dly_active <= {dly_active[DLY-2:0], active};
      dly_hs     <= {dly_hs[DLY-2:0],     hs_raw};
      dly_vs     <= {dly_vs[DLY-2:0],     vs_raw};
      dly_first  <= {dly_first[DLY-2:0],  first_pix};
    end
  end

  // Output register: blank outside the visible window, apply sync polarity
  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= 8'd0;
      g           <= 8'd0;
      b           <= 8'd0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      frame_start <= 1'b0;
    end else begin
      if (dly_active[DLY-1]) begin
        r <= pix_data[23:16];
        g <= pix_data[15:8];
        b <= pix_data[7:0];
      end else begin
        r <= 8'd0;
        g <= 8'd0;
        b <= 8'd0;
      end
      hs          <= dly_hs[DLY-1] ? HS_POL : ~HS_POL;
      vs          <= dly_vs[DLY-1] ? VS_POL : ~VS_POL;
      frame_start <= dly_first[DLY-1];
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Randomized scoreboard bench for vga_scan_ctrl on a reduced raster.
// Expected outputs are derived from the cycle count since reset release.
// Random reset pulses land mid-frame; idle reads return junk that must be blanked.
module tb_vga_scan_ctrl;

  localparam int HA = 16, HF = 2, HSW = 4, HB = 3;
  localparam int VA = 6,  VF = 1, VSW = 2, VB = 2;
  localparam int RL = 3;
  localparam int AW = 7;
  localparam bit HP = 1'b0;
  localparam bit VP = 1'b1;
  localparam int HT    = HA + HF + HSW + HB;
  localparam int VT    = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT   = 2 + RL;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_rd;
  logic [AW-1:0] pix_addr;
  logic [23:0]   pix_data;
  logic          hs, vs;
  logic [7:0]    r, g, b;
  logic          frame_start;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_scan_ctrl #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(HP), .VS_POL(VP), .RD_LATENCY(RL), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst(rst), .pix_rd(pix_rd), .pix_addr(pix_addr),
    .pix_data(pix_data), .hs(hs), .vs(vs), .r(r), .g(g), .b(b),
    .frame_start(frame_start)
  );

  // Frame-buffer model: data = address, junk when no read was issued
  logic [23:0] rd_pipe [RL];
  always @(posedge clk) begin
    if (pix_rd)
      rd_pipe[0] <= {{(24-AW){1'b0}}, pix_addr};
    else
      rd_pipe[0] <= ($urandom_range(0, 1) == 1) ? 24'hFFFFFF : 24'($urandom);
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign pix_data = rd_pipe[RL-1];

  typedef struct {
    logic          rd;
    logic [AW-1:0] addr;
    logic [23:0]   rgb;
    logic          hs;
    logic          vs;
    logic          fs;
  } exp_t;

  exp_t q[$];

  // Raster position -> visibility, address and sync flags
  function automatic void decode(input int pos, output bit act, output int addr,
                                 output bit hsa, output bit vsa);
    int h, v;
    h    = pos % HT;
    v    = pos / HT;
    act  = (h < HA) && (v < VA);
    addr = v * HA + h;
    hsa  = (h >= HA + HF) && (h < HA + HF + HSW);
    vsa  = (v >= VA + VF) && (v < VA + VF + VSW);
  endfunction

  // Reference model: push the expected post-edge state for every clock edge
  int          k = 0;
  logic [AW-1:0] exp_pa = '0;
  always @(posedge clk) begin : model
    exp_t e;
    bit act, hsa, vsa;
    int addr, idx;
    e.rd = 1'b0; e.addr = '0; e.rgb = 24'd0; e.hs = ~HP; e.vs = ~VP; e.fs = 1'b0;
    if (rst) begin
      k      = 0;
      exp_pa = '0;
    end else begin
      k = k + 1;
      decode((k - 1) % FRAME, act, addr, hsa, vsa);
      if (act) exp_pa = AW'(addr);
      e.rd   = act;
      e.addr = exp_pa;
      idx = k - LAT;
      if (idx >= 0) begin
        decode(idx % FRAME, act, addr, hsa, vsa);
        e.rgb = act ? 24'(addr) : 24'd0;
        e.hs  = hsa ? HP : ~HP;
        e.vs  = vsa ? VP : ~VP;
        e.fs  = ((idx % FRAME) == 0);
      end
    end
    q.push_back(e);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare DUT outputs once per cycle, away from the active edge
  always @(negedge clk) begin : monitor
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("pix_rd",      32'(pix_rd),      32'(e.rd));
      check("pix_addr",    32'(pix_addr),    32'(e.addr));
      check("rgb",         32'({r, g, b}),   32'(e.rgb));
      check("hs",          32'(hs),          32'(e.hs));
      check("vs",          32'(vs),          32'(e.vs));
      check("frame_start", 32'(frame_start), 32'(e.fs));
    end
  end

  // Stimulus: initial reset, a multi-frame run, then random runs and reset pulses
  initial begin
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2 * FRAME + 100) @(posedge clk);
    for (int seg = 0; seg < 10; seg++) begin
      #1 rst = 1'b1;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1 rst = 1'b0;
      repeat ($urandom_range(20, 700)) @(posedge clk);
    end
    repeat (2) @(negedge clk);
    #1;
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
